mdio_target: RTL and testbench
==============================

Name: mdio_target

Overview:
- Clause 22 MDIO management target: the PHY-side responder to the station-management controller.
- Oversamples the MDC/MDIO pins on the system clock and decodes preamble, ST, OP, PHYAD, REGAD, TA and DATA.
- Issues register read requests and write strobes to a local register file. On reads, drives turnaround and data back onto the shared MDIO line.
- Sits between the board-level MDIO pins and the PHY/PCS register bank.

Parameters:
- PREAMBLE_BITS, 32: consecutive 1s required before ST is accepted; legal range 20..32.
- SYNC_STAGES, 2: flip-flop stages on the MDC and MDIO inputs; minimum 2.

Ports:
- clk  input  1  system clock; frequency must be at least 8x the MDC frequency.
- reset  input  1  asynchronous, active-high reset.
- phy_addr  input  5  strapped PHY address; treated as static.
- mdc  input  1  management clock from the controller.
- mdio  inout  1  bidirectional data line, declared as wire; driven only when the output enable is set, otherwise 'z'.
- reg_addr  output  5  register address of the current frame.
- reg_rd_req  output  1  one-clk pulse requesting a read of reg_addr.
- reg_rd_data  input  16  read data; must be stable from 1 clk after reg_rd_req until the frame ends.
- reg_wdata  output  16  write data; valid while reg_wr_valid is high.
- reg_wr_valid  output  1  one-clk write strobe.
- busy  output  1  high whenever the state is not PREAMBLE.

Behaviour:
- Reset values: reg_addr=0, reg_wdata=0, reg_rd_req=0, reg_wr_valid=0, mdio output enable=0 (line at 'z'), state=PREAMBLE, preamble count=0, busy=0. Reset mid-frame releases mdio within the same asynchronous event.
- Input sampling:
  - mdc and mdio pass through SYNC_STAGES flops each.
  - rise = mdc_s & ~mdc_s_d.
  - On every rise, sample the synchronized mdio bit. All decoding advances only on a rise.
- Output timing: the mdio value and enable are registered, updating 1 clk after the rise that triggered them, i.e. roughly SYNC_STAGES+1 clk after the pin edge.
- PREAMBLE state:
  - Sampled 1: increment the ones counter, saturating at PREAMBLE_BITS.
  - Sampled 0 with count >= PREAMBLE_BITS: this is ST bit 0; go to START.
  - Sampled 0 with a lower count: clear the count and stay in PREAMBLE.
- START: expect 1. A 1 goes to OPCODE; a 0 goes to PREAMBLE with count=0.
- OPCODE (2 bits, MSB first):
  - 01 = write, 10 = read; both go to PHYAD.
  - 00 or 11 goes to PREAMBLE with count=0.
- PHYAD (5 bits), then REGAD (5 bits), each shifted MSB first.
- On the 5th REGAD rise:
  - PHYAD != phy_addr: go to IGNORE with count 18.
  - Match, read: load reg_addr, pulse reg_rd_req for 1 clk, go to TA.
  - Match, write: load reg_addr, go to TA.
- IGNORE: never drive mdio. Decrement on each rise; at 0 go to PREAMBLE with count=0.
- TA (2 rises):
  - Read: after TA rise 1, enable the output and drive 0. After TA rise 2, load the shift register from reg_rd_data, drive bit 15, go to DATA.
  - Write: the TA bits are not checked; after rise 2 go to DATA.
- DATA (16 rises):
  - Read: each rise shifts left and drives the next bit. Bit 0 is driven after the 15th data rise. The 16th rise releases mdio (enable=0) and goes to PREAMBLE with count=0.
  - Write: each rise shifts the sampled bit in, MSB first. After the 16th rise, reg_wdata is updated and reg_wr_valid pulses for exactly 1 clk; reg_addr holds its value. Then go to PREAMBLE with count=0.
- Back-to-back frames: the preamble count always restarts from 0 after a frame, so a full new preamble is required (no preamble suppression).
- MDC stopping mid-frame: state is held indefinitely. Only reset or further rises advance it.

Decomposition:
- mdio_pkg holds:
  - the state enum: PREAMBLE, START, OPCODE, PHYAD, REGAD, TA, DATA, IGNORE;
  - constants OP_WRITE=2'b01 and OP_READ=2'b10;
  - constant MDIO_DATA_BITS=16.
- One sub-module, mdio_sync: parameterized synchronizer chain for mdc/mdio, plus the rise-pulse output.

Test Plan:
- Read with a match: 32 ones, 01 10, PHYAD=phy_addr=5'h03, REGAD=5'h02, reg_rd_data=16'hA5C3 → one reg_rd_req pulse with reg_addr=2. Target drives 0 on the 2nd TA bit, then bits 1010_0101_1100_0011, then releases to 'z'.
- Write with a match: preamble, 01 01, PHYAD=3, REGAD=5'h1F, TA=10, data 16'h1234 → exactly one reg_wr_valid pulse with reg_wdata=16'h1234 and reg_addr=5'h1F. mdio is never driven.
- Address mismatch: read to PHYAD=4 with phy_addr=3 → no reg_rd_req, mdio stays 'z'. An immediately following valid frame to PHYAD=3 is decoded correctly.
- Short preamble and bad opcode:
  - 20 ones then ST → ignored, busy stays 0.
  - Full preamble with OP=11 → returns to PREAMBLE, no strobes.
- Reset mid-read: assert reset during DATA bit 8 → mdio 'z' immediately, busy=0. A subsequent full write completes normally.
- Back-to-back: write then read with no idle between frames, each with a full 32-bit preamble → both complete. Read data reflects the reg_rd_data supplied for the second frame.

Source files
------------

// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - shared types and constants for the Clause 22 MDIO target
// Contents: frame decoder state enum, opcode encodings, data field width.
package mdio_pkg;

  typedef enum logic [2:0] {
    PREAMBLE,
    START,
    OPCODE,
    PHYAD,
    REGAD,
    TA,
    DATA,
    IGNORE
  } mdio_state_t;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  localparam int MDIO_DATA_BITS = 16;

endpackage

// File: rtl/mdio_sync.sv
// rtl/mdio_sync.sv - synchronizer chains for MDC/MDIO with an MDC rising-edge pulse
// Ports:
//   clk, reset  system clock, asynchronous active-high reset
//   mdc         raw management clock pin
//   mdio_in     raw management data pin
//   mdio_s      synchronized MDIO level
//   rise        one-clk pulse on each synchronized MDC rising edge
module mdio_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic mdc,
  input  logic mdio_in,
  output logic mdio_s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] mdc_q;
  logic [SYNC_STAGES-1:0] mdio_q;
  logic                   mdc_s;
  logic                   mdc_s_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdc_q   <= '0;
      mdio_q  <= '0;
      mdc_s_d <= 1'b0;
    end else begin
      mdc_q   <= {mdc_q[SYNC_STAGES-2:0], mdc};
      mdio_q  <= {mdio_q[SYNC_STAGES-2:0], mdio_in};
      mdc_s_d <= mdc_s;
    end
  end

  assign mdc_s  = mdc_q[SYNC_STAGES-1];
  assign mdio_s = mdio_q[SYNC_STAGES-1];
  assign rise   = mdc_s & ~mdc_s_d;

endmodule

// File: rtl/mdio_target.sv
// rtl/mdio_target.sv - Clause 22 MDIO target: frame decode, register strobes, read-back drive
// Ports:
//   clk, reset    system clock (>= 8x MDC), asynchronous active-high reset
//   phy_addr      strapped PHY address
//   mdc, mdio     management clock in, bidirectional management data
//   reg_addr      register address of the current frame
//   reg_rd_req    one-clk read request; reg_rd_data sampled at the end of turnaround
//   reg_rd_data   read data from the register bank
//   reg_wdata     write data, valid with reg_wr_valid
//   reg_wr_valid  one-clk write strobe
//   busy          high whenever a frame is being decoded
module mdio_target
  import mdio_pkg::*;
#(
  parameter int PREAMBLE_BITS = 32,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  phy_addr,
  input  logic        mdc,
  inout  wire         mdio,
  output logic [4:0]  reg_addr,
  output logic        reg_rd_req,
  input  logic [15:0] reg_rd_data,
  output logic [15:0] reg_wdata,
  output logic        reg_wr_valid,
  output logic        busy
);

  localparam int             PCW          = $clog2(PREAMBLE_BITS + 1);
  localparam logic [PCW-1:0] PRE_FULL     = PCW'(PREAMBLE_BITS);
  localparam int             DW           = MDIO_DATA_BITS;
  localparam logic [3:0]     DATA_LAST    = 4'(DW - 1);
  // Rises left in a foreign frame after REGAD: 2 turnaround + 16 data.
  localparam logic [4:0]     IGNORE_RISES = 5'(DW + 2);

  mdio_state_t    state;
  logic [PCW-1:0] pre_cnt;
  logic [3:0]     bit_cnt;
  logic [4:0]     ign_cnt;
  logic           op_hi;
  logic           is_read;
  logic [4:0]     phyad_sr;
  logic [3:0]     regad_sr;
  // Holds the 15 bits not yet on the wire (read) or the first 15 received (write).
  logic [DW-2:0]  data_sr;
  logic           mdio_oe;
  logic           mdio_out;
  logic           mdio_s;
  logic           rise;

  mdio_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .mdc     (mdc),
    .mdio_in (mdio),
    .mdio_s  (mdio_s),
    .rise    (rise)
  );

  assign mdio = mdio_oe ? mdio_out : 1'bz;
  assign busy = (state != PREAMBLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= PREAMBLE;
      pre_cnt      <= '0;
      bit_cnt      <= '0;
      ign_cnt      <= '0;
      op_hi        <= 1'b0;
      is_read      <= 1'b0;
      phyad_sr     <= '0;
      regad_sr     <= '0;
      data_sr      <= '0;
      mdio_oe      <= 1'b0;
      mdio_out     <= 1'b0;
      reg_addr     <= '0;
      reg_wdata    <= '0;
      reg_rd_req   <= 1'b0;
      reg_wr_valid <= 1'b0;
    end else begin
      reg_rd_req   <= 1'b0;
      reg_wr_valid <= 1'b0;
      if (rise) begin
        unique case (state)
          PREAMBLE: begin
            if (mdio_s) begin
              if (pre_cnt < PRE_FULL) pre_cnt <= pre_cnt + 1'b1;
            end else if (pre_cnt >= PRE_FULL) begin
              // Cleared here so every later return to PREAMBLE sees a zero count,
              // forcing a full preamble before the next frame.
              state   <= START;
              pre_cnt <= '0;
            end else begin
              pre_cnt <= '0;
            end
          end
          START: begin
            bit_cnt <= '0;
            state   <= mdio_s ? OPCODE : PREAMBLE;
          end
          OPCODE: begin
            if (bit_cnt == 4'd0) begin
              op_hi   <= mdio_s;
              bit_cnt <= 4'd1;
            end else begin
              bit_cnt <= '0;
              if ({op_hi, mdio_s} == OP_READ || {op_hi, mdio_s} == OP_WRITE) begin
                is_read <= ({op_hi, mdio_s} == OP_READ);
                state   <= PHYAD;
              end else begin
                state <= PREAMBLE;
              end
            end
          end
          PHYAD: begin
            phyad_sr <= {phyad_sr[3:0], mdio_s};
            if (bit_cnt == 4'd4) begin
              bit_cnt <= '0;
              state   <= REGAD;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          REGAD: begin
            if (bit_cnt == 4'd4) begin
              bit_cnt <= '0;
              if (phyad_sr != phy_addr) begin
                ign_cnt <= IGNORE_RISES;
                state   <= IGNORE;
              end else begin
                reg_addr   <= {regad_sr, mdio_s};
                reg_rd_req <= is_read;
                state      <= TA;
              end
            end else begin
              regad_sr <= {regad_sr[2:0], mdio_s};
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end
          TA: begin
            if (bit_cnt == 4'd0) begin
              bit_cnt <= 4'd1;
              if (is_read) begin
                mdio_oe  <= 1'b1;
                mdio_out <= 1'b0;
              end
            end else begin
              bit_cnt <= '0;
              state   <= DATA;
              if (is_read) begin
                data_sr  <= reg_rd_data[DW-2:0];
                mdio_out <= reg_rd_data[DW-1];
              end
            end
          end
          DATA: begin
            // Reads shift out and ignore the sampled bit; writes shift it in.
            data_sr <= {data_sr[DW-3:0], mdio_s};
            if (is_read) mdio_out <= data_sr[DW-2];
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= PREAMBLE;
              mdio_oe <= 1'b0;
              if (!is_read) begin
                reg_wdata    <= {data_sr, mdio_s};
                reg_wr_valid <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          IGNORE: begin
            ign_cnt <= ign_cnt - 1'b1;
            if (ign_cnt == 5'd1) state <= PREAMBLE;
          end
          default: state <= PREAMBLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_target.sv
// tb/tb_mdio_target.sv - self-checking bench for mdio_target
// Ports: none (top-level bench).
module tb_mdio_target;
  import mdio_pkg::*;

  localparam int PB   = 32;
  localparam int HALF = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mdc = 1'b0;
  logic [4:0]  phy_addr = 5'h03;
  logic [15:0] reg_rd_data = 16'h0000;
  logic [4:0]  reg_addr;
  logic        reg_rd_req;
  logic [15:0] reg_wdata;
  logic        reg_wr_valid;
  logic        busy;
  logic        drv_en = 1'b0;
  logic        drv_val = 1'b1;
  wire         mdio;

  assign mdio = drv_en ? drv_val : 1'bz;
  pullup (mdio);

  always #5 clk = ~clk;

  mdio_target #(.PREAMBLE_BITS(PB), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .phy_addr     (phy_addr),
    .mdc          (mdc),
    .mdio         (mdio),
    .reg_addr     (reg_addr),
    .reg_rd_req   (reg_rd_req),
    .reg_rd_data  (reg_rd_data),
    .reg_wdata    (reg_wdata),
    .reg_wr_valid (reg_wr_valid),
    .busy         (busy)
  );

  int          checks = 0;
  int          errors = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [4:0]  rd_addr_seen = '0;
  logic [4:0]  wr_addr_seen = '0;
  logic [15:0] wr_data_seen = '0;
  bit          busy_seen = 1'b0;

  always @(negedge clk) begin
    if (reg_rd_req) begin
      rd_cnt       = rd_cnt + 1;
      rd_addr_seen = reg_addr;
    end
    if (reg_wr_valid) begin
      wr_cnt       = wr_cnt + 1;
      wr_addr_seen = reg_addr;
      wr_data_seen = reg_wdata;
    end
    if (busy) busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Controller drives on MDC low, target samples on MDC rise.
  task automatic tx_bit(input logic b);
    drv_en  = 1'b1;
    drv_val = b;
    #HALF mdc = 1'b1;
    #HALF mdc = 1'b0;
  endtask

  // Controller releases the line and samples just before the rising edge.
  task automatic rx_bit(output logic b);
    drv_en = 1'b0;
    #(HALF - 1);
    b = mdio;
    #1 mdc = 1'b1;
    #HALF mdc = 1'b0;
  endtask

  task automatic send_header(input int ones, input logic [1:0] op,
                             input logic [4:0] pa, input logic [4:0] ra);
    for (int i = 0; i < ones; i++) tx_bit(1'b1);
    tx_bit(1'b0);
    tx_bit(1'b1);
    tx_bit(op[1]);
    tx_bit(op[0]);
    for (int i = 4; i >= 0; i--) tx_bit(pa[i]);
    for (int i = 4; i >= 0; i--) tx_bit(ra[i]);
  endtask

  // Read opcodes release the line for TA + data and capture 18 sampled bits.
  task automatic frame(input int ones, input logic [1:0] op, input logic [4:0] pa,
                       input logic [4:0] ra, input logic [15:0] wd, output logic [17:0] rx);
    logic b;
    rx = '1;
    send_header(ones, op, pa, ra);
    if (op == OP_READ) begin
      for (int i = 17; i >= 0; i--) begin
        rx_bit(b);
        rx[i] = b;
      end
    end else begin
      tx_bit(1'b1);
      tx_bit(1'b0);
      for (int i = 15; i >= 0; i--) tx_bit(wd[i]);
    end
  endtask

  // Reference: a frame is served only with a full preamble, a legal opcode
  // and our PHY address. Read-back is z (pulled to 1), 0, then data MSB first.
  task automatic do_frame(input string tag, input int ones, input logic [1:0] op,
                          input logic [4:0] pa, input logic [4:0] ra,
                          input logic [15:0] wd, input logic [15:0] rd);
    int          rd0;
    int          wr0;
    logic [17:0] rx;
    logic [17:0] rx_exp;
    bit          acc;
    bit          exp_rd;
    bit          exp_wr;
    reg_rd_data = rd;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    busy_seen = 1'b0;
    frame(ones, op, pa, ra, wd, rx);
    acc    = (ones >= PB) && (op == OP_READ || op == OP_WRITE) && (pa == phy_addr);
    exp_rd = acc && (op == OP_READ);
    exp_wr = acc && (op == OP_WRITE);
    check({tag, ".rd_req_count"}, 32'(rd_cnt - rd0), {31'd0, exp_rd});
    check({tag, ".wr_valid_count"}, 32'(wr_cnt - wr0), {31'd0, exp_wr});
    check({tag, ".busy_seen"}, {31'd0, busy_seen}, {31'd0, (ones >= PB)});
    check({tag, ".busy_end"}, {31'd0, busy}, 32'd0);
    if (op == OP_READ) begin
      rx_exp = exp_rd ? {2'b10, rd} : '1;
      check({tag, ".read_bits"}, {14'd0, rx}, {14'd0, rx_exp});
      check({tag, ".released"}, {31'd0, mdio}, 32'd1);
    end
    if (exp_rd) check({tag, ".rd_addr"}, {27'd0, rd_addr_seen}, {27'd0, ra});
    if (exp_wr) begin
      check({tag, ".wr_data"}, {16'd0, wr_data_seen}, {16'd0, wd});
      check({tag, ".wr_addr"}, {27'd0, wr_addr_seen}, {27'd0, ra});
      check({tag, ".reg_addr_hold"}, {27'd0, reg_addr}, {27'd0, ra});
      check({tag, ".reg_wdata_hold"}, {16'd0, reg_wdata}, {16'd0, wd});
    end
  endtask

  initial begin
    logic       b;
    logic [4:0] pa;
    logic [4:0] ra;
    logic [1:0] op;
    int         ones;
    int         rd0;

    #1 reset = 1'b1;
    #2;
    check("reset.reg_addr", {27'd0, reg_addr}, 32'd0);
    check("reset.reg_wdata", {16'd0, reg_wdata}, 32'd0);
    check("reset.rd_req", {31'd0, reg_rd_req}, 32'd0);
    check("reset.wr_valid", {31'd0, reg_wr_valid}, 32'd0);
    check("reset.busy", {31'd0, busy}, 32'd0);
    check("reset.mdio_released", {31'd0, mdio}, 32'd1);
    #100 reset = 1'b0;

    do_frame("read_match", PB, OP_READ, 5'h03, 5'h02, 16'h0000, 16'hA5C3);
    do_frame("write_match", PB, OP_WRITE, 5'h03, 5'h1F, 16'h1234, 16'h0000);
    do_frame("read_mismatch", PB, OP_READ, 5'h04, 5'h07, 16'h0000, 16'hFFFF);
    do_frame("read_after_mismatch", PB, OP_READ, 5'h03, 5'h0A, 16'h0000, 16'(
             $urandom));
    do_frame("short20", 20, OP_READ, 5'h03, 5'h02, 16'h0000, 16'h5A5A);
    do_frame("bad_op11", PB, 2'b11, 5'h03, 5'h02, 16'hFFFF, 16'h0000);
    do_frame("write_after_bad", PB, OP_WRITE, 5'h03, 5'h11, 16'(
             $urandom), 16'h0000);
    do_frame("short31", PB - 1, OP_WRITE, 5'h03, 5'h05, 16'hBEEF, 16'h0000);

    // Reset during the read data phase, while a 0 is on the line.
    reg_rd_data = 16'h0000;
    rd0 = rd_cnt;
    send_header(PB, OP_READ, 5'h03, 5'h05);
    for (int i = 0; i < 10; i++) rx_bit(b);
    check("midread.rd_req", 32'(rd_cnt - rd0), 32'd1);
    check("midread.driving", {31'd0, mdio}, 32'd0);
    check("midread.busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("midread.reset_release", {31'd0, mdio}, 32'd1);
    check("midread.reset_busy", {31'd0, busy}, 32'd0);
    #19 reset = 1'b0;
    do_frame("write_after_reset", PB, OP_WRITE, 5'h03, 5'h0C, 16'hC0DE, 16'h0000);

    do_frame("b2b_write", PB, OP_WRITE, 5'h03, 5'h06, 16'h8001, 16'h0000);
    do_frame("b2b_read", PB, OP_READ, 5'h03, 5'h06, 16'h0000, 16'h3C96);

    for (int n = 0; n < 12; n++) begin
      pa   = ($urandom_range(0, 1) == 1) ? phy_addr : 5'($urandom);
      ra   = 5'($urandom);
      op   = 2'($urandom);
      ones = PB + int'($urandom_range(0, 6));
      do_frame($sformatf("rand%0d", n), ones, op, pa, ra, 16'($urandom), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
